// File: rtl/fmul_pipe.sv
// fmul_pipe: IEEE-754 single-precision multiplier with a parametrised
// pipeline depth and a valid/ready handshake.
//
// Datapath split:
//   front: operand decode, special-value classification, exponent sum and
//          four 12x12 partial products of the 24-bit significands.
//   back : partial-product sum, 1-bit normalise, rounding, range checks,
//          special-value override and pack.
// front feeds NSTAGE-1 middle registers, and back feeds the output register,
// so there are exactly NSTAGE registers between operand capture and y.
// For NSTAGE = 1 front and back form one combinational cone into the
// output register.
//
// Flow control is a simple global stall: every stage advances together when
// the output register is empty or being drained. Bubbles are not collapsed.

module fmul_pipe #(
  parameter int NSTAGE = 3,
  parameter int ROUND  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf,
  output logic        nv
);

  // Middle-stage bundle layout, MSB first:
  //   valid(1) sign(1) esum(10) cls(3) pp_hh(24) pp_hl(24) pp_lh(24) pp_ll(24)
  localparam int MW = 111;

  // Operand-pair classes, resolved in priority order during decode.
  localparam logic [2:0] CLS_NORM = 3'd0;
  localparam logic [2:0] CLS_NAN  = 3'd1;
  localparam logic [2:0] CLS_INV  = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_ZERO = 3'd4;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  if ((NSTAGE < 1) || (NSTAGE > 4)) begin : g_bad_nstage
    $error("fmul_pipe: NSTAGE must be in the range 1..4");
  end

  // Decode both operands and form the partial products. Subnormals have
  // exp = 0 and are treated as zero, so their fraction bits never matter.
  function automatic logic [MW-2:0] front_f(input logic [31:0] a,
                                            input logic [31:0] b);
    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [22:0] fa;
    logic [22:0] fb;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic [2:0]  cls;
    logic [9:0]  esum;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [23:0] pp_hh;
    logic [23:0] pp_hl;
    logic [23:0] pp_lh;
    logic [23:0] pp_ll;
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    if (a_nan || b_nan) begin
      cls = CLS_NAN;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      cls = CLS_INV;
    end else if (a_inf || b_inf) begin
      cls = CLS_INF;
    end else if (a_zero || b_zero) begin
      cls = CLS_ZERO;
    end else begin
      cls = CLS_NORM;
    end
    esum  = {2'b00, ea} + {2'b00, eb} - 10'd127;
    ma    = {1'b1, fa};
    mb    = {1'b1, fb};
    pp_hh = {12'd0, ma[23:12]} * {12'd0, mb[23:12]};
    pp_hl = {12'd0, ma[23:12]} * {12'd0, mb[11:0]};
    pp_lh = {12'd0, ma[11:0]}  * {12'd0, mb[23:12]};
    pp_ll = {12'd0, ma[11:0]}  * {12'd0, mb[11:0]};
    return {sa ^ sb, esum, cls, pp_hh, pp_hl, pp_lh, pp_ll};
  endfunction

  // Sum partial products, normalise, round, range-check and pack.
  // Returns {y, ovf, udf, nv}; everything is zero for a bubble so the flags
  // are never asserted without out_valid.
  function automatic logic [34:0] back_f(input logic [MW-1:0] m);
    logic        vld;
    logic        sgn;
    logic [9:0]  esum;
    logic [2:0]  cls;
    logic [23:0] pp_hh;
    logic [23:0] pp_hl;
    logic [23:0] pp_lh;
    logic [23:0] pp_ll;
    logic [47:0] prod;
    logic        nrm;
    logic [22:0] frac;
    logic        grd;
    logic        stk;
    logic        inc;
    logic [23:0] frac_rnd;
    logic [9:0]  e_fin;
    logic [31:0] res;
    logic        o_f;
    logic        u_f;
    logic        n_f;
    {vld, sgn, esum, cls, pp_hh, pp_hl, pp_lh, pp_ll} = m;
    prod = {pp_hh, 24'd0}
         + {12'd0, pp_hl, 12'd0}
         + {12'd0, pp_lh, 12'd0}
         + {24'd0, pp_ll};
    nrm = prod[47];
    if (nrm) begin
      frac = prod[46:24];
      grd  = prod[23];
      stk  = |prod[22:0];
    end else begin
      frac = prod[45:23];
      grd  = prod[22];
      stk  = |prod[21:0];
    end
    if (ROUND != 0) begin
      inc = grd & (stk | frac[0]);
    end else begin
      inc = 1'b0;
    end
    // A carry out of the rounded fraction leaves the field at zero (1.0 x 2),
    // so only the exponent needs the extra increment.
    frac_rnd = {1'b0, frac} + {23'd0, inc};
    e_fin    = esum + {9'd0, nrm} + {9'd0, frac_rnd[23]};
    o_f = 1'b0;
    u_f = 1'b0;
    n_f = 1'b0;
    case (cls)
      CLS_NAN: begin
        res = QNAN;
      end
      CLS_INV: begin
        res = QNAN;
        n_f = 1'b1;
      end
      CLS_INF: begin
        res = {sgn, 8'hFF, 23'd0};
      end
      CLS_ZERO: begin
        res = {sgn, 31'd0};
      end
      CLS_NORM: begin
        if ($signed(e_fin) >= 10'sd255) begin
          res = {sgn, 8'hFF, 23'd0};
          o_f = 1'b1;
        end else if ($signed(e_fin) <= 10'sd0) begin
          res = {sgn, 31'd0};
          u_f = 1'b1;
        end else begin
          res = {sgn, e_fin[7:0], frac_rnd[22:0]};
        end
      end
      default: begin
        res = QNAN;
        n_f = 1'b1;
      end
    endcase
    if (vld) begin
      return {res, o_f, u_f, n_f};
    end else begin
      return 35'd0;
    end
  endfunction

  logic          adv_s;
  logic [MW-1:0] back_in_s;
  logic [34:0]   back_out_s;
  logic          out_valid_r;
  logic [31:0]   y_r;
  logic          ovf_r;
  logic          udf_r;
  logic          nv_r;

  assign adv_s      = ~out_valid_r | out_ready;
  assign in_ready   = adv_s;
  assign back_out_s = back_f(back_in_s);

  if (NSTAGE == 1) begin : g_s1
    assign back_in_s = {in_valid, front_f(x1, x2)};
  end else begin : g_sn
    logic [MW-1:0] mid_r [0:NSTAGE-2];

    // Middle stages: capture decoded operands and shift forward on advance.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < NSTAGE - 1; i++) begin
          mid_r[i] <= {MW{1'b0}};
        end
      end else if (adv_s) begin
        mid_r[0] <= {in_valid, front_f(x1, x2)};
        for (int i = 1; i < NSTAGE - 1; i++) begin
          mid_r[i] <= mid_r[i-1];
        end
      end
    end

    assign back_in_s = mid_r[NSTAGE-2];
  end

  // Output stage: load the packed result on advance, hold it while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_r <= 1'b0;
      y_r         <= 32'd0;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
      nv_r        <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= back_in_s[MW-1];
      {y_r, ovf_r, udf_r, nv_r} <= back_out_s;
    end
  end

  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign ovf       = ovf_r;
  assign udf       = udf_r;
  assign nv        = nv_r;

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- IEEE-754 single-precision multiplier; next generation of the FPU multiplier.
- Adds a parametrised pipeline depth, a valid/ready handshake with back-pressure, selectable rounding (truncate or round-to-nearest-even) and full special-value handling.
- Exception flags (overflow, underflow, invalid) are carried alongside each result.
- Sits between the FPU issue stage and the FPU writeback mux.

Parameters:
- NSTAGE, 3, pipeline latency in cycles; legal range 1..4; any other value is an elaboration error.
- ROUND, 1, 0 = truncate toward zero, 1 = round-to-nearest-even.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- x1  input  32  operand A.
- x2  input  32  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result this cycle.
- y  output  32  product.
- ovf  output  1  overflow flag for y.
- udf  output  1  underflow flag for y.
- nv  output  1  invalid-operation flag for y.

Behaviour:
- One clock domain; reset is asynchronous and active-low (rstn); no other reset.
- Reset state: every stage valid bit = 0, so out_valid = 0; y = 0, ovf = udf = nv = 0; in_ready = 1 once rstn is deasserted.
- Reset asserted mid-operation: all in-flight operations are discarded and no result is emitted for them.
- Pipeline advance: adv = ~out_valid | out_ready.
  - in_ready = adv (purely combinational; no dependence on in_valid).
  - On adv, every stage register shifts forward by one and stage 0 captures the operands plus in_valid.
  - On ~adv, all stages hold, including bubbles. This gives a simple stall with no bubble collapsing.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Latency and throughput:
  - Without stalls, an operation accepted at cycle t has out_valid = 1 at cycle t+NSTAGE.
  - Throughput is 1 per cycle.
  - Results emerge in order. None are dropped or duplicated.
- Holding: while out_valid & ~out_ready, y and the flags stay stable.
- Arithmetic:
  - Sign = s1 ^ s2, including zeros and infinities.
  - Subnormal inputs (exp = 0) are flushed to signed zero before use.
  - Mantissa product is the full 24x24 = 48-bit product of {1,m1} and {1,m2}.
  - Normalise by 1 bit if product bit 47 is set.
  - Biased exponent = e1 + e2 - 127 + norm, computed at 10 bits signed.
  - Rounding on the 23-bit field:
    - ROUND = 1: guard and sticky from the discarded bits, RNE with ties to even.
    - ROUND = 0: drop the discarded bits.
    - A rounding carry-out renormalises and increments the exponent; this is checked before the overflow test.
  - Final exponent >= 255: result is signed infinity, ovf = 1.
  - Final exponent <= 0: result is signed zero (flush; no subnormal outputs), udf = 1.
- Special cases, with priority top-down:
  - Either operand NaN: y = 0x7FC00000, nv = 0.
  - Inf times zero (after flush): y = 0x7FC00000, nv = 1.
  - Inf times finite: signed infinity, flags 0.
  - Zero times finite: signed zero, flags 0.
- Flag timing: ovf, udf and nv are only meaningful while out_valid = 1 and are 0 otherwise.
- Stage partitioning (fixed point first, then distributed across NSTAGE):
  - Decode and special detection first.
  - Partial products, e.g. a 12x12 split, in the middle.
  - Sum, normalise, round and pack last.
  - Retiming is free, but the architectural latency must equal NSTAGE exactly.

Test Plan:
- Basic product: x1 = 0x3FC00000, x2 = 0x40000000, out_ready = 1 → y = 0x40400000 exactly NSTAGE cycles later, all flags 0.
- Rounding tie: x1 = 0x3F800001, x2 = 0x3FC00000 → y = 0x3FC00002 with ROUND = 1; y = 0x3FC00001 with ROUND = 0.
- Overflow and underflow:
  - 0x7F000000 * 0x7F000000 → y = 0x7F800000, ovf = 1.
  - 0x00800000 * 0x3F000000 → y = 0x00000000, udf = 1.
  - 0x80800000 * 0x3F000000 → y = 0x80000000, udf = 1.
- Specials:
  - 0x7F800000 * 0x00000000 → y = 0x7FC00000, nv = 1.
  - 0xFF800000 * 0x40000000 → y = 0xFF800000, flags 0.
  - 0x7FC12345 * 0x3F800000 → y = 0x7FC00000, nv = 0.
  - 0x00000001 (subnormal) * 0x40000000 → y = 0x00000000.
- Back-pressure: stream 8 random operand pairs back-to-back while out_ready toggles 1,0,0,1,...
  - All 8 results arrive in order and match the reference model.
  - in_ready = 0 exactly when out_valid & ~out_ready.
  - y is stable during stalls.
- Reset mid-stream: assert rstn = 0 asynchronously, off a clock edge, with NSTAGE operations in flight.
  - out_valid drops to 0 immediately.
  - After release, no stale results appear.
  - The first new operation's result appears NSTAGE cycles after acceptance.
